tick_counter: RTL and testbench

TICK_COUNTER -- requirements
Module: tick_counter

---
 rtl/tick_counter_pkg.sv | 24 ++
 rtl/tick_counter_if.sv | 30 +++
 rtl/tick_counter_delay_line.sv | 45 ++++
 rtl/tick_counter.sv | 123 ++++++++++++
 tb/tb_tick_counter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_counter_pkg.sv
// Shared constants and types for the modulo tick counter.
// Holds the watch cascade moduli, widths and output alignment delays.
package tick_counter_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int SEC_BITS  = 6;
  localparam int MIN_BITS  = 6;
  localparam int HOUR_BITS = 5;

  localparam int SEC_DLY  = 2;
  localparam int MIN_DLY  = 1;
  localparam int HOUR_DLY = 0;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_CLEAR,
    EV_LOAD,
    EV_ADV
  } cnt_ev_e;

endpackage

// File: rtl/tick_counter_if.sv
// Control and status bundle of one tick_counter stage.
// master drives the controls, slave is the counter itself.
interface tick_counter_if #(
  parameter int COUNT_BIT = 6
) ();

  logic                 i_run_en;
  logic                 i_tick;
  logic                 i_dir;
  logic [COUNT_BIT-1:0] i_mod;
  logic                 i_clear;
  logic                 i_load;
  logic [COUNT_BIT-1:0] i_load_val;
  logic                 o_tick;
  logic [COUNT_BIT-1:0] o_cnt_val;
  logic                 o_load_err;

  modport master (
    output i_run_en, i_tick, i_dir, i_mod,
    output i_clear, i_load, i_load_val,
    input  o_tick, o_cnt_val, o_load_err
  );

  modport slave (
    input  i_run_en, i_tick, i_dir, i_mod,
    input  i_clear, i_load, i_load_val,
    output o_tick, o_cnt_val, o_load_err
  );

endinterface

// File: rtl/tick_counter_delay_line.sv
// Fixed-depth register pipeline with synchronous reset.
// DEPTH of zero passes the input straight through.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int SZ = (DEPTH < 1) ? 1 : DEPTH;

  generate
    if (DEPTH < 0 || DEPTH > 3) begin : g_bad_depth
      $fatal(1, "delay_line: DEPTH must be 0..3");
    end
  endgenerate

  logic [WIDTH-1:0] stage_q [SZ];
  logic [WIDTH-1:0] stage_d [SZ];

  // shift: stage 0 takes the input, others take their predecessor
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SZ; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // pipeline registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SZ; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = (DEPTH == 0) ? d : stage_q[SZ-1];

endmodule

// File: rtl/tick_counter.sv
// Up/down modulo counter stage with carry/borrow tick output.
// Cascades into sec/min/hour chains; o_cnt_val can be delay-aligned.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int COUNT_BIT = 6,
  parameter int MAX_CNT   = 60,
  parameter int DELAY_OUT = 0
) (
  input  logic           clk,
  input  logic           reset,
  tick_counter_if.slave  bus
);

  localparam int W = COUNT_BIT + 1;

  generate
    if (MAX_CNT < 2 || MAX_CNT > (1 << COUNT_BIT)) begin : g_bad_max
      $fatal(1, "tick_counter: MAX_CNT out of range");
    end
    if (DELAY_OUT < 0 || DELAY_OUT > 3) begin : g_bad_dly
      $fatal(1, "tick_counter: DELAY_OUT must be 0..3");
    end
  endgenerate

  logic [COUNT_BIT-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic                 err_q, err_d;
  logic [W-1:0]         mod_w;
  logic [W-1:0]         mod_eff;
  logic [COUNT_BIT-1:0] m_last;
  logic                 load_ok;
  cnt_ev_e              ev;

  // effective modulus: fall back to MAX_CNT for unusable i_mod
  always_comb begin
    mod_w = {1'b0, bus.i_mod};
    if (mod_w >= W'(2) && mod_w <= W'(MAX_CNT)) begin
      mod_eff = mod_w;
    end else begin
      mod_eff = W'(MAX_CNT);
    end
    m_last  = COUNT_BIT'(mod_eff - W'(1));
    load_ok = {1'b0, bus.i_load_val} < mod_eff;
  end

  // pick the single winning event: clear > load > advance
  always_comb begin
    ev = EV_NONE;
    if (bus.i_clear) begin
      ev = EV_CLEAR;
    end else if (bus.i_load) begin
      ev = EV_LOAD;
    end else if (bus.i_run_en && bus.i_tick) begin
      ev = EV_ADV;
    end
  end

  // next count, wrap tick and load error for the chosen event
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    err_d  = 1'b0;
    unique case (ev)
      EV_CLEAR: cnt_d = '0;
      EV_LOAD: begin
        if (load_ok) begin
          cnt_d = bus.i_load_val;
        end else begin
          cnt_d = '0;
          err_d = 1'b1;
        end
      end
      EV_ADV: begin
        if (!bus.i_dir) begin
          if (cnt_q >= m_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + COUNT_BIT'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d  = m_last;
            tick_d = 1'b1;
          end else if (cnt_q > m_last) begin
            cnt_d = m_last;
          end else begin
            cnt_d = cnt_q - COUNT_BIT'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_tick     = tick_q;
  assign bus.o_load_err = err_q;

  delay_line #(
    .WIDTH (COUNT_BIT),
    .DEPTH (DELAY_OUT)
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_q),
    .q     (bus.o_cnt_val)
  );

endmodule

// File: tb/tb_tick_counter.sv
// Random + directed bench for tick_counter against a reference model.
// Also exercises a sec/min/hour cascade with aligned outputs.
module tb_tick_counter;
  import tick_counter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  int m_cnt = 0;
  bit m_tick = 1'b0;
  bit m_err = 1'b0;

  tick_counter_if #(.COUNT_BIT(6)) m_if ();

  tick_counter #(
    .COUNT_BIT (6),
    .MAX_CNT   (60),
    .DELAY_OUT (0)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (m_if)
  );

  tick_counter_if #(.COUNT_BIT(SEC_BITS))  s_if ();
  tick_counter_if #(.COUNT_BIT(MIN_BITS))  n_if ();
  tick_counter_if #(.COUNT_BIT(HOUR_BITS)) h_if ();

  tick_counter #(
    .COUNT_BIT (SEC_BITS),
    .MAX_CNT   (SEC_MOD),
    .DELAY_OUT (SEC_DLY)
  ) u_sec (
    .clk   (clk),
    .reset (c_rst),
    .bus   (s_if)
  );

  tick_counter #(
    .COUNT_BIT (MIN_BITS),
    .MAX_CNT   (MIN_MOD),
    .DELAY_OUT (MIN_DLY)
  ) u_min (
    .clk   (clk),
    .reset (c_rst),
    .bus   (n_if)
  );

  tick_counter #(
    .COUNT_BIT (HOUR_BITS),
    .MAX_CNT   (HOUR_MOD),
    .DELAY_OUT (HOUR_DLY)
  ) u_hour (
    .clk   (clk),
    .reset (c_rst),
    .bus   (h_if)
  );

  assign n_if.i_tick = s_if.o_tick;
  assign h_if.i_tick = n_if.o_tick;

  // reference model: what the count must be after each edge
  always @(posedge clk) begin : ref_model
    int md;
    if (rst) begin
      m_cnt  = 0;
      m_tick = 1'b0;
      m_err  = 1'b0;
    end else begin
      md = int'(m_if.i_mod);
      if (md < 2 || md > 60) md = 60;
      m_tick = 1'b0;
      m_err  = 1'b0;
      if (m_if.i_clear) begin
        m_cnt = 0;
      end else if (m_if.i_load) begin
        if (int'(m_if.i_load_val) < md) begin
          m_cnt = int'(m_if.i_load_val);
        end else begin
          m_cnt = 0;
          m_err = 1'b1;
        end
      end else if (m_if.i_run_en && m_if.i_tick) begin
        if (!m_if.i_dir) begin
          if (m_cnt + 1 >= md) begin
            m_cnt  = 0;
            m_tick = 1'b1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else if (m_cnt == 0) begin
          m_cnt  = md - 1;
          m_tick = 1'b1;
        end else if (m_cnt >= md) begin
          m_cnt = md - 1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (m_if.o_cnt_val !== 6'(m_cnt) || m_if.o_tick !== m_tick ||
          m_if.o_load_err !== m_err) begin
        bad++;
        $display("FAIL model t=%0t cnt=%0d/%0d tick=%b/%b err=%b/%b",
                 $time, m_if.o_cnt_val, m_cnt, m_if.o_tick, m_tick,
                 m_if.o_load_err, m_err);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    m_if.i_clear = 1'b0;
    m_if.i_load  = 1'b0;
    m_if.i_tick  = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  int nt;

  initial begin
    m_if.i_run_en   = 1'b0;
    m_if.i_tick     = 1'b0;
    m_if.i_dir      = 1'b0;
    m_if.i_mod      = 6'd60;
    m_if.i_clear    = 1'b0;
    m_if.i_load     = 1'b0;
    m_if.i_load_val = '0;
    s_if.i_run_en = 1'b1;
    s_if.i_tick   = 1'b0;
    s_if.i_dir    = 1'b0;
    s_if.i_mod    = 6'(SEC_MOD);
    s_if.i_clear  = 1'b0;
    s_if.i_load   = 1'b0;
    s_if.i_load_val = '0;
    n_if.i_run_en = 1'b1;
    n_if.i_dir    = 1'b0;
    n_if.i_mod    = 6'(MIN_MOD);
    n_if.i_clear  = 1'b0;
    n_if.i_load   = 1'b0;
    n_if.i_load_val = '0;
    h_if.i_run_en = 1'b1;
    h_if.i_dir    = 1'b0;
    h_if.i_mod    = 5'(HOUR_MOD);
    h_if.i_clear  = 1'b0;
    h_if.i_load   = 1'b0;
    h_if.i_load_val = '0;

    cyc();
    chk_on = 1'b1;
    chk("rst_cnt", int'(m_if.o_cnt_val), 0);
    chk("rst_tick", int'(m_if.o_tick), 0);
    chk("rst_err", int'(m_if.o_load_err), 0);
    rst = 1'b0;

    // full up lap with i_tick held high
    m_if.i_run_en = 1'b1;
    m_if.i_tick   = 1'b1;
    nt = 0;
    for (int i = 1; i <= 61; i++) begin
      cyc();
      nt += int'(m_if.o_tick);
      if (i == 59) chk("lap_59", int'(m_if.o_cnt_val), 59);
      if (i == 60) chk("lap_wrap", int'(m_if.o_cnt_val), 0);
      if (i == 60) chk("lap_tick", int'(m_if.o_tick), 1);
      if (i == 61) chk("lap_after", int'(m_if.o_cnt_val), 1);
    end
    chk("lap_ntick", nt, 1);

    // down wrap at modulus 24
    idle();
    m_if.i_clear = 1'b1;
    cyc();
    idle();
    m_if.i_dir  = 1'b1;
    m_if.i_mod  = 6'd24;
    m_if.i_tick = 1'b1;
    cyc();
    chk("dn_wrap", int'(m_if.o_cnt_val), 23);
    chk("dn_tick", int'(m_if.o_tick), 1);
    cyc();
    chk("dn_22", int'(m_if.o_cnt_val), 22);
    chk("dn_notick", int'(m_if.o_tick), 0);

    // load handling
    idle();
    m_if.i_mod = 6'd60;
    m_if.i_load = 1'b1;
    m_if.i_load_val = 6'd45;
    cyc();
    chk("ld_45", int'(m_if.o_cnt_val), 45);
    chk("ld_45_err", int'(m_if.o_load_err), 0);
    m_if.i_load_val = 6'd61;
    cyc();
    chk("ld_61", int'(m_if.o_cnt_val), 0);
    chk("ld_61_err", int'(m_if.o_load_err), 1);
    idle();
    cyc();
    chk("ld_err_gone", int'(m_if.o_load_err), 0);
    m_if.i_load = 1'b1;
    m_if.i_load_val = 6'd45;
    m_if.i_clear = 1'b1;
    cyc();
    chk("clr_ld", int'(m_if.o_cnt_val), 0);

    // modulus shrink while out of range
    idle();
    m_if.i_load = 1'b1;
    m_if.i_load_val = 6'd50;
    cyc();
    idle();
    m_if.i_mod = 6'd24;
    cyc();
    chk("shrink_hold", int'(m_if.o_cnt_val), 50);
    m_if.i_dir = 1'b0;
    m_if.i_tick = 1'b1;
    cyc();
    chk("shrink_up", int'(m_if.o_cnt_val), 0);
    chk("shrink_up_t", int'(m_if.o_tick), 1);
    idle();
    m_if.i_mod = 6'd60;
    m_if.i_load = 1'b1;
    cyc();
    idle();
    m_if.i_mod = 6'd24;
    m_if.i_dir = 1'b1;
    m_if.i_tick = 1'b1;
    cyc();
    chk("shrink_dn", int'(m_if.o_cnt_val), 23);
    chk("shrink_dn_t", int'(m_if.o_tick), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      m_if.i_clear = ($urandom_range(0, 29) == 0);
      m_if.i_load = ($urandom_range(0, 14) == 0);
      m_if.i_load_val = 6'($urandom_range(0, 63));
      m_if.i_run_en = ($urandom_range(0, 3) != 0);
      m_if.i_tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) m_if.i_dir = ~m_if.i_dir;
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 2))
          0: m_if.i_mod = 6'd60;
          1: m_if.i_mod = 6'd24;
          default: m_if.i_mod = 6'($urandom_range(0, 63));
        endcase
      end
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    // cascade: 23:59:59 -> 00:00:00
    c_rst = 1'b0;
    s_if.i_load = 1'b1;
    s_if.i_load_val = 6'd59;
    n_if.i_load = 1'b1;
    n_if.i_load_val = 6'd59;
    h_if.i_load = 1'b1;
    h_if.i_load_val = 5'd23;
    cyc();
    s_if.i_load = 1'b0;
    n_if.i_load = 1'b0;
    h_if.i_load = 1'b0;
    repeat (3) cyc();
    chk("cas_s59", int'(s_if.o_cnt_val), 59);
    chk("cas_m59", int'(n_if.o_cnt_val), 59);
    chk("cas_h23", int'(h_if.o_cnt_val), 23);
    s_if.i_tick = 1'b1;
    cyc();
    s_if.i_tick = 1'b0;
    chk("cas_stick", int'(s_if.o_tick), 1);
    cyc();
    chk("cas_n2_s", int'(s_if.o_cnt_val), 59);
    chk("cas_n2_h", int'(h_if.o_cnt_val), 23);
    cyc();
    chk("cas_s0", int'(s_if.o_cnt_val), 0);
    chk("cas_m0", int'(n_if.o_cnt_val), 0);
    chk("cas_h0", int'(h_if.o_cnt_val), 0);
    chk("cas_htick", int'(h_if.o_tick), 1);

    // cascade: reset lands on the wrap
    s_if.i_load = 1'b1;
    n_if.i_load = 1'b1;
    h_if.i_load = 1'b1;
    cyc();
    s_if.i_load = 1'b0;
    n_if.i_load = 1'b0;
    h_if.i_load = 1'b0;
    repeat (3) cyc();
    chk("cas2_s59", int'(s_if.o_cnt_val), 59);
    s_if.i_tick = 1'b1;
    c_rst = 1'b1;
    cyc();
    s_if.i_tick = 1'b0;
    c_rst = 1'b0;
    nt = 0;
    for (int i = 0; i < 4; i++) begin
      nt += int'(s_if.o_tick) + int'(n_if.o_tick) + int'(h_if.o_tick);
      chk("cas2_disp",
          int'(s_if.o_cnt_val) + int'(n_if.o_cnt_val) +
          int'(h_if.o_cnt_val), 0);
      cyc();
    end
    chk("cas2_ntick", nt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
